// File: rtl/door_sequencer_pkg.sv
// door_sequencer_pkg -- shared definitions for the garage-door supervisory sequencer.
//   state_e    : one-hot sequencer states
//   LIM_*      : decode of the limit-switch pair {Up_max, Dn_max}
package door_sequencer_pkg;

  typedef enum logic [5:0] {
    S_INIT    = 6'b000001,
    S_CLOSED  = 6'b000010,
    S_OPENING = 6'b000100,
    S_OPEN    = 6'b001000,
    S_CLOSING = 6'b010000,
    S_FAULT   = 6'b100000
  } state_e;

  // {Up_max, Dn_max}
  localparam logic [1:0] LIM_CLOSED = 2'b01;
  localparam logic [1:0] LIM_OPEN   = 2'b10;
  localparam logic [1:0] LIM_ERR    = 2'b11;

endpackage

// File: rtl/door_sequencer_btn_sync.sv
// door_btn_sync -- two-flop synchroniser plus rising-edge detector for the raw button.
//   clock     in  system clock, rising edge
//   reset     in  asynchronous active-low reset
//   button    in  raw asynchronous button level
//   btn_pulse out one-cycle pulse, two clocks after the button rises
module door_btn_sync (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic btn_pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= button;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign btn_pulse = sync & ~sync_d;

endmodule

// File: rtl/door_sequencer.sv
// door_sequencer -- supervisory sequencer in front of the garage-door FSM.
// Cleans the button into a single activate pulse, auto-closes an open door,
// and latches a sticky fault on travel timeout or inconsistent limits/motors.
//   clock, reset        clock (rising edge), asynchronous active-low reset
//   button              raw remote/wall button
//   auto_close_en       enable auto-close while open
//   Up_max, Dn_max      fully-open / fully-closed limit switches
//   Up_motor, Dn_motor  door FSM motor drive readback
//   activate            registered one-cycle request pulse to the door FSM
//   fault               sticky fault flag (cleared only by reset)
//   lamp                courtesy lamp, present only with DOOR_SEQ_LAMP_EN defined
module door_sequencer
  import door_sequencer_pkg::*;
#(
  parameter int unsigned AUTO_CLOSE_CYCLES = 1000,
  parameter int unsigned MAX_RUN_CYCLES    = 500,
  parameter int unsigned LAMP_HOLD_CYCLES  = 200,
  parameter int unsigned CNT_W             = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic auto_close_en,
  input  logic Up_max,
  input  logic Dn_max,
  input  logic Up_motor,
  input  logic Dn_motor,
  output logic activate,
`ifdef DOOR_SEQ_LAMP_EN
  output logic lamp,
`endif
  output logic fault
);

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CLOSE_CYCLES - 1);

  state_e           state, state_next;
  logic [CNT_W-1:0] timer, timer_next, timer_inc;
  logic             act_next;
  logic             btn_pulse;
  logic [1:0]       limits;

  door_btn_sync u_btn_sync (
    .clock     (clock),
    .reset     (reset),
    .button    (button),
    .btn_pulse (btn_pulse)
  );

  assign limits    = {Up_max, Dn_max};
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_INIT;
      timer    <= '0;
      activate <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      activate <= act_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    act_next   = 1'b0;
    case (state)
      S_INIT: begin
        if (limits == LIM_CLOSED) begin
          state_next = S_CLOSED;
          timer_next = '0;
        end else if (limits == LIM_OPEN) begin
          state_next = S_OPEN;
          timer_next = '0;
        end else if (timer == RUN_LAST) begin
          state_next = S_FAULT;
        end else begin
          timer_next = timer_inc;
        end
      end
      S_CLOSED: begin
        timer_next = '0;
        if (btn_pulse) begin
          act_next   = 1'b1;
          state_next = S_OPENING;
        end
      end
      S_OPENING: begin
        if (limits == LIM_OPEN) begin
          state_next = S_OPEN;
          timer_next = '0;
        end else if (timer == RUN_LAST) begin
          state_next = S_FAULT;
        end else begin
          timer_next = timer_inc;
        end
      end
      S_OPEN: begin
        // Button and auto-close expiry share one branch so a coincidence yields one pulse.
        if (btn_pulse || (auto_close_en && timer == AUTO_LAST)) begin
          act_next   = 1'b1;
          state_next = S_CLOSING;
          timer_next = '0;
        end else if (auto_close_en) begin
          timer_next = timer_inc;
        end else begin
          timer_next = '0;
        end
      end
      S_CLOSING: begin
        if (limits == LIM_CLOSED) begin
          state_next = S_CLOSED;
          timer_next = '0;
        end else if (timer == RUN_LAST) begin
          state_next = S_FAULT;
        end else begin
          timer_next = timer_inc;
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
    // Inconsistent limits or both motors driven override everything else.
    if (limits == LIM_ERR || (Up_motor && Dn_motor)) begin
      state_next = S_FAULT;
      act_next   = 1'b0;
    end
  end

  assign fault = (state == S_FAULT);

`ifdef DOOR_SEQ_LAMP_EN
  localparam logic [CNT_W-1:0] LAMP_HOLD = CNT_W'(LAMP_HOLD_CYCLES);

  logic [CNT_W-1:0] lamp_cnt, lamp_cnt_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lamp_cnt <= '0;
    else        lamp_cnt <= lamp_cnt_next;
  end

  // Hold is loaded on entry to a resting state and cleared when travel restarts.
  always_comb begin
    lamp_cnt_next = (lamp_cnt != '0) ? lamp_cnt - 1'b1 : lamp_cnt;
    if (state_next != state && (state_next == S_OPEN || state_next == S_CLOSED))
      lamp_cnt_next = LAMP_HOLD;
    if (state_next == S_OPENING || state_next == S_CLOSING)
      lamp_cnt_next = '0;
  end

  assign lamp = (state == S_OPENING) || (state == S_CLOSING) ||
                (state == S_FAULT) || (lamp_cnt != '0);
`endif

endmodule

// File: tb/tb_door_sequencer.sv
// tb_door_sequencer -- directed self-checking bench for door_sequencer
// (AUTO_CLOSE_CYCLES=8, MAX_RUN_CYCLES=6, LAMP_HOLD_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_door_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic button = 1'b0;
  logic auto_close_en = 1'b0;
  logic Up_max = 1'b0;
  logic Dn_max = 1'b0;
  logic Up_motor = 1'b0;
  logic Dn_motor = 1'b0;
  logic activate;
  logic fault;
`ifdef DOOR_SEQ_LAMP_EN
  logic lamp;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  door_sequencer #(
    .AUTO_CLOSE_CYCLES (8),
    .MAX_RUN_CYCLES    (6),
    .LAMP_HOLD_CYCLES  (4),
    .CNT_W             (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button        (button),
    .auto_close_en (auto_close_en),
    .Up_max        (Up_max),
    .Dn_max        (Dn_max),
    .Up_motor      (Up_motor),
    .Dn_motor      (Dn_motor),
    .activate      (activate),
`ifdef DOOR_SEQ_LAMP_EN
    .lamp          (lamp),
`endif
    .fault         (fault)
  );

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; Dn_max = 1'b1; Up_max = 1'b0; button = 1'b0; auto_close_en = 1'b0;
    step(2);
    checks++;
    if (activate !== 1'b0) begin errors++; $display("FAIL reset_activate got=%b exp=0", activate); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
    reset = 1'b1;
    step(1);
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL closed_fault got=%b exp=0", fault); end
  endtask

  // Ends in S_OPENING with timer 0 and the button still held.
  task automatic test_button_pulse;
    button = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      checks++;
      if (activate !== (i == 3)) begin
        errors++; $display("FAIL btn_latency cyc=%0d got=%b exp=%b", i, activate, (i == 3));
      end
    end
  endtask

  task automatic test_auto_close;
    Dn_max = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++;
      if (activate !== 1'b0) begin errors++; $display("FAIL btn_held got=%b exp=0", activate); end
    end
    Up_max = 1'b1; auto_close_en = 1'b1;
    step(1);
    for (int i = 1; i <= 9; i++) begin
      step(1);
      checks++;
      if (activate !== (i == 8)) begin
        errors++; $display("FAIL auto_close cyc=%0d got=%b exp=%b", i, activate, (i == 8));
      end
    end
    Up_max = 1'b0; step(1);
    Dn_max = 1'b1; step(1);
    button = 1'b0; step(3);
    // Re-open with auto-close disabled.
    button = 1'b1; step(3);
    checks++;
    if (activate !== 1'b1) begin errors++; $display("FAIL reopen got=%b exp=1", activate); end
    Dn_max = 1'b0; step(1);
    Up_max = 1'b1; auto_close_en = 1'b0; step(1);
    for (int i = 0; i < 50; i++) begin
      step(1);
      checks++;
      if (activate !== 1'b0) begin errors++; $display("FAIL no_auto cyc=%0d got=%b exp=0", i, activate); end
    end
  endtask

  // Button edge lands in the same cycle the auto-close timer reaches 7.
  task automatic test_same_cycle;
    button = 1'b0; step(3);
    auto_close_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      checks++;
      if (activate !== 1'b0) begin errors++; $display("FAIL coinc_pre cyc=%0d got=%b exp=0", i, activate); end
    end
    button = 1'b1;
    for (int i = 6; i <= 10; i++) begin
      step(1);
      checks++;
      if (activate !== (i == 8)) begin
        errors++; $display("FAIL coinc cyc=%0d got=%b exp=%b", i, activate, (i == 8));
      end
    end
    Up_max = 1'b0; step(1);
    Dn_max = 1'b1; step(1);
    button = 1'b0; auto_close_en = 1'b0;
  endtask

  task automatic test_open_timeout;
    step(3);
    button = 1'b1; step(3);
    checks++;
    if (activate !== 1'b1) begin errors++; $display("FAIL to_open got=%b exp=1", activate); end
    Dn_max = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      checks++;
      if (fault !== (i == 6)) begin
        errors++; $display("FAIL run_timeout cyc=%0d got=%b exp=%b", i, fault, (i == 6));
      end
    end
    button = 1'b0; step(3);
    button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++;
      if (activate !== 1'b0) begin errors++; $display("FAIL fault_act cyc=%0d got=%b exp=0", i, activate); end
    end
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b exp=1", fault); end
  endtask

  task automatic test_limit_conflict;
    reset = 1'b0; Up_max = 1'b0; Dn_max = 1'b1; button = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_clears got=%b exp=0", fault); end
    step(1);
    reset = 1'b1; step(1);
    Up_max = 1'b1; step(1);
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL limit_err got=%b exp=1", fault); end
    reset = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL async_reset got=%b exp=0", fault); end
    Up_max = 1'b0; Dn_max = 1'b0;
    @(negedge clock);
  endtask

  // Released from reset between limits: button ignored until a limit is reached.
  task automatic test_reset_mid_travel;
    reset = 1'b1; button = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      checks++;
      if (activate !== 1'b0) begin errors++; $display("FAIL init_act cyc=%0d got=%b exp=0", i, activate); end
    end
    Dn_max = 1'b1; step(1);
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL init_closed got=%b exp=0", fault); end
    button = 1'b0; step(3);
    button = 1'b1; step(3);
    checks++;
    if (activate !== 1'b1) begin errors++; $display("FAIL after_init got=%b exp=1", activate); end
    Dn_max = 1'b0; Up_motor = 1'b1; Dn_motor = 1'b1; step(1);
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL motor_conflict got=%b exp=1", fault); end
  endtask

  task automatic test_init_timeout;
    reset = 1'b0; Up_motor = 1'b0; Dn_motor = 1'b0; Up_max = 1'b0; Dn_max = 1'b0; button = 1'b0;
    step(1);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      checks++;
      if (fault !== (i == 6)) begin
        errors++; $display("FAIL init_timeout cyc=%0d got=%b exp=%b", i, fault, (i == 6));
      end
    end
  endtask

`ifdef DOOR_SEQ_LAMP_EN
  task automatic test_lamp;
    reset = 1'b0; Dn_max = 1'b1; Up_max = 1'b0; button = 1'b0; auto_close_en = 1'b0;
    step(1);
    reset = 1'b1; step(6);
    checks++;
    if (lamp !== 1'b0) begin errors++; $display("FAIL lamp_idle got=%b exp=0", lamp); end
    button = 1'b1; step(3);
    checks++;
    if (lamp !== 1'b1) begin errors++; $display("FAIL lamp_opening got=%b exp=1", lamp); end
    button = 1'b0; Dn_max = 1'b0; step(1);
    Up_max = 1'b1; step(1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (lamp !== (i < 4)) begin errors++; $display("FAIL lamp_open cyc=%0d got=%b exp=%b", i, lamp, (i < 4)); end
      step(1);
    end
    button = 1'b1; step(3);
    checks++;
    if (lamp !== 1'b1) begin errors++; $display("FAIL lamp_closing got=%b exp=1", lamp); end
    Up_max = 1'b0; step(1);
    Dn_max = 1'b1; step(1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (lamp !== (i < 4)) begin errors++; $display("FAIL lamp_closed cyc=%0d got=%b exp=%b", i, lamp, (i < 4)); end
      step(1);
    end
  endtask
`endif

  initial begin
    @(negedge clock);
    test_reset;
    test_button_pulse;
    test_auto_close;
    test_same_cycle;
    test_open_timeout;
    test_limit_conflict;
    test_reset_mid_travel;
    test_init_timeout;
`ifdef DOOR_SEQ_LAMP_EN
    test_lamp;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
